// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame check, show-ahead scancode FIFO.
// Latency: pin fall to fall strobe is SYNC_STAGES+FILTER_LEN cycles; push at stop-bit fall, visible next cycle.
// Backpressure: none toward the PS/2 line; a good frame arriving into a full FIFO with no pop is dropped and flags overflow.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clear_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   filt_q;
  logic [FC_W-1:0]        fcnt_q;
  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   par_q;
  logic [TO_W-1:0]        tcnt_q;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d, ferr_q, ferr_d;

  logic clk_s, dat_s, flip, fall, timeout, frame_good, push, bad;
  logic pop, full, wr, ovf_set;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Bring both PS/2 lines into the clk domain; idle-high lines reset to 1
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign flip = (clk_s != filt_q) && (fcnt_q == FC_W'(FILTER_LEN - 1));
  // The strobe coincides with the flip so the data sample and the edge share one cycle
  assign fall = flip && filt_q;

  // Glitch filter: count differing samples, restart whenever the sample agrees
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_s == filt_q) begin
      fcnt_q <= '0;
    end else if (flip) begin
      filt_q <= ~filt_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign timeout    = (state_q != IDLE) && !fall && (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign frame_good = (^{shift_q, par_q}) && dat_s;
  assign push       = (state_q == STOP) && fall && frame_good;
  assign bad        = ((state_q == STOP) && fall && !frame_good) || timeout;

  // Frame FSM with inter-edge timeout; a timeout abandons the partial byte
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      if (state_q == IDLE || fall) tcnt_q <= '0;
      else                         tcnt_q <= tcnt_q + 1'b1;
      if (timeout) begin
        state_q <= IDLE;
      end else if (fall) begin
        case (state_q)
          IDLE: if (!dat_s) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
          DATA: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_s;
            state_q <= STOP;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A pop frees the head slot, so a push into a full FIFO is accepted when paired with a pop
  assign pop     = rd_en && rd_valid;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr      = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // Occupancy and sticky-flag next state; a new error wins over clear_err
  always_comb begin
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + 1'b1;
    else if (!wr && pop) count_d = count_q - 1'b1;
    ovf_d  = ovf_set | (ovf_q  & ~clear_err);
    ferr_d = bad     | (ferr_q & ~clear_err);
  end

  // FIFO pointers, occupancy and sticky flags
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  // Storage array; contents are only observable while the entry is occupied
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: expected scancodes queued at send time, checked on every pop.
// Directed PS/2 frames with 20-cycle half periods; status outputs checked at fixed points.
// Reads are driven only by the bench; the DUT never stalls the PS/2 stimulus.
module tb_ps2_rx_fifo;
  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       frame_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  ps2_rx_fifo #(
    .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(200), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .nRst(nRst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .clear_err(clear_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected scancode
  always @(negedge clk) begin
    if (nRst && rd_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no data", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("pop_data", {24'h0, rd_data}, {24'h0, e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
  endtask

  // One PS/2 frame (or its first nbits bits); optional mid-bit glitches and a read aligned to the push cycle
  task automatic send(input logic [7:0] b, input int nbits, input bit bad_par,
                      input bit bad_stop, input bit glitch, input bit rd_at_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      for (int c = 0; c < 20; c++) begin
        ps2_clk = !(glitch && (c == 10 || c == 11));
        cyc(1);
      end
      ps2_clk = 1'b0;
      for (int c = 0; c < 20; c++) begin
        rd_en = rd_at_stop && (i == 10) && (c == 5);
        cyc(1);
      end
      rd_en   = 1'b0;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(20);
  endtask

  initial begin
    // Reset state
    cyc(3);
    smp();
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    @(posedge clk); #1;
    nRst = 1'b1;
    cyc(5);

    // 1: single frame then pop
    exp_q.push_back(8'h1C);
    send(8'h1C, 11, 0, 0, 0, 0);
    smp();
    chk("t1_rd_data", rd_data, 8'h1C);
    chk("t1_rd_valid", rd_valid, 1'b1);
    chk("t1_count", fifo_count, 3'd1);
    chk("t1_frame_err", frame_err, 1'b0);
    chk("t1_overflow", overflow, 1'b0);
    pulse_rd();
    smp();
    chk("t1_rd_valid_after", rd_valid, 1'b0);
    chk("t1_count_after", fifo_count, 3'd0);

    // 2: glitched clock, then bad parity
    exp_q.push_back(8'hF0);
    send(8'hF0, 11, 0, 0, 1, 0);
    exp_q.push_back(8'h1C);
    send(8'h1C, 11, 0, 0, 1, 0);
    smp();
    chk("t2_count", fifo_count, 3'd2);
    chk("t2_frame_err_glitch", frame_err, 1'b0);
    pulse_rd();
    pulse_rd();
    send(8'h1C, 11, 1, 0, 0, 0);
    smp();
    chk("t2_count_badpar", fifo_count, 3'd0);
    chk("t2_frame_err_badpar", frame_err, 1'b1);
    pulse_clr();
    smp();
    chk("t2_frame_err_clr", frame_err, 1'b0);

    // 3: bad stop bit
    send(8'h55, 11, 0, 1, 0, 0);
    smp();
    chk("t3_count", fifo_count, 3'd0);
    chk("t3_frame_err", frame_err, 1'b1);
    pulse_clr();

    // 4: clock stalls after 5 bits, then a good frame
    send(8'h12, 5, 0, 0, 0, 0);
    smp();
    chk("t4_no_early_timeout", frame_err, 1'b0);
    cyc(300);
    smp();
    chk("t4_frame_err", frame_err, 1'b1);
    chk("t4_count", fifo_count, 3'd0);
    pulse_clr();
    exp_q.push_back(8'h5A);
    send(8'h5A, 11, 0, 0, 0, 0);
    smp();
    chk("t4_count_5a", fifo_count, 3'd1);
    chk("t4_frame_err_5a", frame_err, 1'b0);
    pulse_rd();

    // 5: overflow, drain, push+pop while full
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send(8'(k), 11, 0, 0, 0, 0);
    end
    smp();
    chk("t5_count_full", fifo_count, 3'd4);
    chk("t5_overflow", overflow, 1'b1);
    chk("t5_head", rd_data, 8'h01);
    for (int k = 0; k < 4; k++) pulse_rd();
    smp();
    chk("t5_count_drained", fifo_count, 3'd0);
    pulse_clr();
    smp();
    chk("t5_overflow_clr", overflow, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h11 + 8'(k));
      send(8'h11 + 8'(k), 11, 0, 0, 0, 0);
    end
    exp_q.push_back(8'h06);
    send(8'h06, 11, 0, 0, 0, 1);
    smp();
    chk("t5_count_pushpop", fifo_count, 3'd4);
    chk("t5_overflow_pushpop", overflow, 1'b0);
    chk("t5_head_pushpop", rd_data, 8'h12);
    for (int k = 0; k < 4; k++) pulse_rd();
    smp();
    chk("t5_count_end", fifo_count, 3'd0);

    // 6: reset mid-frame with entries buffered
    exp_q.push_back(8'h33);
    send(8'h33, 11, 0, 0, 0, 0);
    exp_q.push_back(8'h44);
    send(8'h44, 11, 0, 0, 0, 0);
    send(8'h1C, 11, 1, 0, 0, 0);
    send(8'h77, 3, 0, 0, 0, 0);
    smp();
    chk("t6_count_pre", fifo_count, 3'd2);
    chk("t6_frame_err_pre", frame_err, 1'b1);
    @(posedge clk); #1;
    nRst = 1'b0;
    exp_q.delete();
    smp();
    chk("t6_rd_data", rd_data, 8'h00);
    chk("t6_rd_valid", rd_valid, 1'b0);
    chk("t6_count", fifo_count, 3'd0);
    chk("t6_overflow", overflow, 1'b0);
    chk("t6_frame_err", frame_err, 1'b0);
    cyc(3);
    nRst = 1'b1;
    cyc(5);
    exp_q.push_back(8'h29);
    send(8'h29, 11, 0, 0, 0, 0);
    smp();
    chk("t6_count_29", fifo_count, 3'd1);
    chk("t6_head_29", rd_data, 8'h29);
    pulse_rd();
    smp();
    chk("t6_count_end", fifo_count, 3'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
